// File: rtl/datapath_pkg.sv
// Shared definitions for param_datapath: bus source/load bit positions,
// memory access FSM states and default widths.
package datapath_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_IMM_W    = 19;

  localparam int SRC_REG = 0;
  localparam int SRC_ZHI = 1;
  localparam int SRC_ZLO = 2;
  localparam int SRC_PC  = 3;
  localparam int SRC_MDR = 4;
  localparam int SRC_IMM = 5;
  localparam int SRC_W   = 6;

  localparam int DST_REG = 0;
  localparam int DST_Y   = 1;
  localparam int DST_Z   = 2;
  localparam int DST_MAR = 3;
  localparam int DST_MDR = 4;
  localparam int DST_PC  = 5;
  localparam int DST_IR  = 6;
  localparam int DST_W   = 7;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Req/ack memory access sequencer: captures address, data and direction at
// issue, holds mem_req until ack, and strobes the MDR load for completed reads.
module mem_access_fsm
  import datapath_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start_rd_i,
  input  logic              start_wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              mdr_load_o
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    mdr_load_o = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous read and write request issues as a write.
        if (start_rd_i || start_wr_i) begin
          state_d = WAIT;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = start_wr_i;
        end
      end
      WAIT: begin
        if (mem_ack_i) begin
          state_d    = IDLE;
          mdr_load_o = !we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q == WAIT);
  assign mem_req_o   = (state_q == WAIT);
  assign mem_we_o    = (state_q == WAIT) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/param_datapath.sv
// Single-bus datapath: register file, Y, Z, PC, IR, MAR, MDR and a req/ack memory port.
// PARAM_DATAPATH_BUS_CHECK_EN enables the sticky multi-driver bus_err flag.
module param_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int IMM_W     = DEF_IMM_W,
  parameter int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [REG_IDX_W-1:0] reg_in_idx,
  input  logic [REG_IDX_W-1:0] reg_out_idx,
  input  logic                 ba_out,
  input  logic [SRC_W-1:0]     src_oe,
  input  logic [DST_W-1:0]     dst_le,
  input  logic                 inc_pc,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  output logic                 mem_busy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic [DATA_W-1:0]    alu_a,
  input  logic [2*DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]    bus,
  output logic [DATA_W-1:0]    ir,
  output logic                 bus_err
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   y_q, pc_q, pc_d, ir_q, mdr_q;
  logic [2*DATA_W-1:0] z_q;
  logic [ADDR_W-1:0]   mar_q;
  logic [DATA_W-1:0]   bus_val, reg_rd, imm_ext;
  logic                reg_out_ok, reg_in_ok, busy, mdr_load;

  assign reg_out_ok = (int'(reg_out_idx) < NUM_REGS);
  assign reg_in_ok  = (int'(reg_in_idx) < NUM_REGS);
  assign imm_ext    = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  always_comb begin
    reg_rd = '0;
    // Base-address mode turns R0 into a constant zero for address arithmetic.
    if (reg_out_ok && !(ba_out && reg_out_idx == '0)) begin
      reg_rd = regs_q[reg_out_idx];
    end
  end

  always_comb begin
    bus_val = '0;
    if (src_oe[SRC_REG])      bus_val = reg_rd;
    else if (src_oe[SRC_ZHI]) bus_val = z_q[2*DATA_W-1:DATA_W];
    else if (src_oe[SRC_ZLO]) bus_val = z_q[DATA_W-1:0];
    else if (src_oe[SRC_PC])  bus_val = pc_q;
    else if (src_oe[SRC_MDR]) bus_val = mdr_q;
    else if (src_oe[SRC_IMM]) bus_val = imm_ext;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (dst_le[DST_REG] && reg_in_ok) begin
      regs_q[reg_in_idx] <= bus_val;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (dst_le[DST_PC]) pc_d = bus_val;
    else if (inc_pc)    pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      y_q   <= '0;
      z_q   <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (dst_le[DST_Y])           y_q   <= bus_val;
      if (dst_le[DST_Z])           z_q   <= alu_result;
      if (dst_le[DST_IR])          ir_q  <= bus_val;
      // MAR and MDR are frozen while an access is outstanding.
      if (dst_le[DST_MAR] && !busy) mar_q <= bus_val[ADDR_W-1:0];
      if (mdr_load)                mdr_q <= mem_rdata;
      else if (dst_le[DST_MDR] && !busy) mdr_q <= bus_val;
    end
  end

  mem_access_fsm #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem_fsm (
    .clk        (clk),
    .clr        (clr),
    .start_rd_i (mem_rd),
    .start_wr_i (mem_wr),
    .addr_i     (mar_q),
    .wdata_i    (mdr_q),
    .mem_ack_i  (mem_ack),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .busy_o     (busy),
    .mdr_load_o (mdr_load)
  );

`ifdef PARAM_DATAPATH_BUS_CHECK_EN
  logic bus_err_q;
  logic multi_drv;

  assign multi_drv = |(src_oe & (src_oe - 6'd1));

  always_ff @(posedge clk) begin
    if (clr)            bus_err_q <= 1'b0;
    else if (multi_drv) bus_err_q <= 1'b1;
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign mem_busy = busy;
  assign alu_a    = y_q;
  assign bus      = bus_val;
  assign ir       = ir_q;

endmodule

// File: tb/tb_param_datapath.sv
// Directed and randomized bench for param_datapath against a cycle-level behavioural model.
module tb_param_datapath;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 9;
  localparam int IW = 19;
  localparam int RW = 4;
`ifdef PARAM_DATAPATH_BUS_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr;
  logic [RW-1:0] reg_in_idx, reg_out_idx;
  logic          ba_out;
  logic [5:0]    src_oe;
  logic [6:0]    dst_le;
  logic          inc_pc, mem_rd, mem_wr;
  logic          mem_busy, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] alu_a;
  logic [2*DW-1:0] alu_result;
  logic [DW-1:0] bus, ir;
  logic          bus_err;

  param_datapath #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .IMM_W(IW)) dut (
    .clk(clk), .clr(clr), .reg_in_idx(reg_in_idx), .reg_out_idx(reg_out_idx),
    .ba_out(ba_out), .src_oe(src_oe), .dst_le(dst_le), .inc_pc(inc_pc),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_busy(mem_busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_a(alu_a),
    .alu_result(alu_result), .bus(bus), .ir(ir), .bus_err(bus_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state
  logic [DW-1:0]   m_regs [NR];
  logic [DW-1:0]   m_y, m_pc, m_ir, m_mdr, m_wdata;
  logic [2*DW-1:0] m_z;
  logic [AW-1:0]   m_mar, m_addr;
  bit              m_busy, m_we, m_err;

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_y = '0; m_pc = '0; m_ir = '0; m_mdr = '0; m_wdata = '0;
    m_z = '0; m_mar = '0; m_addr = '0;
    m_busy = 0; m_we = 0; m_err = 0;
  endtask

  function automatic logic [DW-1:0] m_bus();
    longint v;
    for (int i = 0; i < 6; i++) begin
      if (src_oe[i]) begin
        case (i)
          0: begin
            if (int'(reg_out_idx) >= NR || (ba_out && reg_out_idx == 0)) return '0;
            return m_regs[reg_out_idx];
          end
          1: return m_z[2*DW-1:DW];
          2: return m_z[DW-1:0];
          3: return m_pc;
          4: return m_mdr;
          default: begin
            v = longint'(m_ir[IW-1:0]);
            if (v >= (longint'(1) << (IW-1))) v = v - (longint'(1) << IW);
            return DW'(v);
          end
        endcase
      end
    end
    return '0;
  endfunction

  task automatic idle();
    reg_in_idx = '0; reg_out_idx = '0; ba_out = 0; src_oe = '0; dst_le = '0;
    inc_pc = 0; mem_rd = 0; mem_wr = 0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic drv(input logic [5:0] s, input logic [6:0] d);
    idle();
    src_oe = s;
    dst_le = d;
  endtask

  // Check outputs mid-cycle, advance the model, then cross the rising edge.
  task automatic tick();
    logic [DW-1:0] b;
    logic [AW-1:0] old_mar;
    logic [DW-1:0] old_mdr;
    @(negedge clk);
    b = m_bus();
    chk("bus", bus, b);
    chk("mem_req", mem_req, m_busy);
    chk("mem_busy", mem_busy, m_busy);
    chk("mem_we", mem_we, m_busy && m_we);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("alu_a", alu_a, m_y);
    chk("ir", ir, m_ir);
    chk("bus_err", bus_err, m_err);
    if (mem_req) req_cycles++;
    if (clr) begin
      m_reset();
    end else begin
      old_mar = m_mar;
      old_mdr = m_mdr;
      if (dst_le[0] && int'(reg_in_idx) < NR) m_regs[reg_in_idx] = b;
      if (dst_le[1]) m_y = b;
      if (dst_le[2]) m_z = alu_result;
      if (dst_le[6]) m_ir = b;
      if (dst_le[5]) m_pc = b;
      else if (inc_pc) m_pc = m_pc + 1;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0;
          if (!m_we) m_mdr = mem_rdata;
        end
      end else begin
        if (dst_le[3]) m_mar = b[AW-1:0];
        if (dst_le[4]) m_mdr = b;
        if (mem_rd || mem_wr) begin
          m_busy  = 1;
          m_we    = mem_wr;
          m_addr  = old_mar;
          m_wdata = old_mdr;
        end
      end
      if (EXP_ERR && $countones(src_oe) > 1) m_err = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_z(input logic [2*DW-1:0] v);
    drv(6'b0, 7'b0000100);
    alu_result = v;
    tick();
  endtask

  int lat;

  initial begin
    idle();
    alu_result = '0;
    m_reset();
    clr = 1;
    tick();
    tick();
    clr = 0;

    // Reset state
    drv(6'b001000, 7'b0);
    #1 chk("rst_pc", bus, 32'h0);
    tick();
    drv(6'b010000, 7'b0);
    #1 chk("rst_mdr", bus, 32'h0);
    chk("rst_req", mem_req, 0);
    tick();

    // Immediate sign extension into R5, base-address mode on R0
    load_z(64'h7FFFF);
    drv(6'b000100, 7'b1000000); tick();
    drv(6'b100000, 7'b0000001); reg_in_idx = 5; tick();
    drv(6'b000001, 7'b0); reg_out_idx = 5;
    #1 chk("r5_imm", bus, 32'hFFFF_FFFF);
    tick();
    drv(6'b100000, 7'b0000001); reg_in_idx = 0; tick();
    drv(6'b000001, 7'b0); reg_out_idx = 0; ba_out = 1;
    #1 chk("ba_r0_zero", bus, 32'h0);
    tick();
    ba_out = 0;
    #1 chk("r0_plain", bus, 32'hFFFF_FFFF);
    tick();

    // PC wrap and load-over-increment priority
    drv(6'b100000, 7'b0100000); tick();
    drv(6'b0, 7'b0); inc_pc = 1; tick();
    drv(6'b001000, 7'b0);
    #1 chk("pc_wrap", bus, 32'h0);
    tick();
    load_z(64'h40);
    drv(6'b000100, 7'b0100000); inc_pc = 1; tick();
    drv(6'b001000, 7'b0);
    #1 chk("pc_load_wins", bus, 32'h40);
    tick();

    // Read with 3-cycle ack; MAR load and mem_wr during busy ignored
    load_z(64'h1A5);
    drv(6'b000100, 7'b0001000); tick();
    drv(6'b0, 7'b0); mem_rd = 1; tick();
    req_cycles = 0;
    drv(6'b001000, 7'b0001000); mem_wr = 1;
    #1 chk("rd_addr", mem_addr, 9'h1A5);
    chk("rd_we", mem_we, 0);
    tick();
    drv(6'b0, 7'b0); tick();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; tick();
    drv(6'b010000, 7'b0);
    #1 chk("rd_data", bus, 32'hDEAD_BEEF);
    chk("rd_req_cycles", req_cycles, 3);
    chk("rd_req_drop", mem_req, 0);
    tick();

    // Simultaneous rd+wr issues a write; MDR unaffected by ack
    load_z(64'h1234);
    drv(6'b000100, 7'b0010000); tick();
    drv(6'b0, 7'b0); mem_rd = 1; mem_wr = 1; tick();
    drv(6'b0, 7'b0);
    #1 chk("wr_we", mem_we, 1);
    chk("wr_wdata", mem_wdata, 32'h1234);
    chk("wr_addr_frozen_mar", mem_addr, 9'h1A5);
    tick();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D; tick();
    drv(6'b010000, 7'b0);
    #1 chk("wr_mdr_kept", bus, 32'h1234);
    tick();

    // clr in second WAIT cycle aborts; late ack ignored
    drv(6'b0, 7'b0); mem_rd = 1; tick();
    drv(6'b0, 7'b0); tick();
    clr = 1; tick();
    clr = 0;
    drv(6'b0, 7'b0);
    #1 chk("clr_abort_req", mem_req, 0);
    mem_ack = 1; mem_rdata = 32'h0BAD_0BAD; tick();
    drv(6'b010000, 7'b0);
    #1 chk("clr_mdr", bus, 32'h0);
    tick();

    // Multi-driver bus
    load_z(64'h55AA);
    drv(6'b000100, 7'b0000001); reg_in_idx = 5; tick();
    drv(6'b000011, 7'b0); reg_out_idx = 5;
    #1 chk("multi_sel", bus, 32'h55AA);
    tick();
    drv(6'b0, 7'b0);
    #1 chk("bus_err_set", bus_err, EXP_ERR);
    tick(); tick();
    #1 chk("bus_err_sticky", bus_err, EXP_ERR);
    clr = 1; tick();
    clr = 0;
    #1 chk("bus_err_clr", bus_err, 0);
    tick();

    // Randomized traffic
    lat = $urandom_range(0, 3);
    for (int n = 0; n < 800; n++) begin
      idle();
      if ($urandom_range(0, 3) == 0) src_oe = 6'($urandom_range(0, 63));
      else src_oe = 6'(1 << $urandom_range(0, 5));
      dst_le      = 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127));
      reg_in_idx  = RW'($urandom_range(0, NR - 1));
      reg_out_idx = RW'($urandom_range(0, NR - 1));
      ba_out      = ($urandom_range(0, 3) == 0);
      inc_pc      = ($urandom_range(0, 2) == 0);
      mem_rd      = ($urandom_range(0, 4) == 0);
      mem_wr      = ($urandom_range(0, 5) == 0);
      alu_result  = {$urandom, $urandom};
      mem_rdata   = $urandom;
      if (m_busy) begin
        if (lat == 0) begin
          mem_ack = 1;
          lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 9) == 0);
      end
      clr = ($urandom_range(0, 99) == 0);
      tick();
    end
    clr = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
